// File: rtl/control_sequencer.sv
// Hardwired control unit: fetches a 16-bit instruction as two bytes, then decodes
// and drives every datapath control line for a single EXEC cycle.
module control_sequencer #(
    parameter logic [5:0]  HALT_OPC = 6'h3F,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [15:0]      IROut,
    input  logic [3:0]       ALU_FlagsOut,
    output logic [2:0]       RF_OutASel,
    output logic [2:0]       RF_OutBSel,
    output logic [2:0]       RF_FunSel,
    output logic [3:0]       RF_RegSel,
    output logic [3:0]       RF_ScrSel,
    output logic [4:0]       ALU_FunSel,
    output logic             ALU_WF,
    output logic [1:0]       ARF_OutCSel,
    output logic [1:0]       ARF_OutDSel,
    output logic [2:0]       ARF_FunSel,
    output logic [2:0]       ARF_RegSel,
    output logic             IR_LH,
    output logic             IR_Write,
    output logic             Mem_WR,
    output logic             Mem_CS,
    output logic [1:0]       MuxASel,
    output logic [1:0]       MuxBSel,
    output logic             MuxCSel,
    output logic             Halted,
    output logic [CNT_W-1:0] InstrCount
);

    typedef enum logic [2:0] {
        StInit   = 3'd0,
        StFetchL = 3'd1,
        StFetchH = 3'd2,
        StExec   = 3'd3,
        StHalt   = 3'd4
    } state_e;

    localparam logic [2:0] FunDec     = 3'b000;
    localparam logic [2:0] FunInc     = 3'b001;
    localparam logic [2:0] FunLoad    = 3'b010;
    localparam logic [2:0] FunClr     = 3'b011;
    localparam logic [2:0] FunLoadLow = 3'b101;

    localparam logic [5:0] OpBra  = 6'h00;
    localparam logic [5:0] OpBeq  = 6'h01;
    localparam logic [5:0] OpBne  = 6'h02;
    localparam logic [5:0] OpLdar = 6'h03;
    localparam logic [5:0] OpLd   = 6'h04;
    localparam logic [5:0] OpSt   = 6'h05;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [5:0] opc;
    logic [1:0] rx;
    logic [1:0] ry;
    logic       flag_z;
    logic       branch_taken;
    logic       is_alu_op;

    assign opc    = IROut[15:10];
    assign rx     = IROut[9:8];
    assign ry     = IROut[7:6];
    assign flag_z = ALU_FlagsOut[3];

    // Branch target comes straight from IROut[7:0] via MuxB; only Z matters here.
    assign branch_taken = (opc == OpBra) || (opc == OpLdar) ||
                          ((opc == OpBeq) && flag_z) || ((opc == OpBne) && !flag_z);
    assign is_alu_op    = (opc[5:3] == 3'b001);

    logic unused_inputs;
    assign unused_inputs = ^{ALU_FlagsOut[2:0], IROut[5:0], FunDec};

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= StInit;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            StInit:   state_d = StFetchL;
            StFetchL: state_d = StFetchH;
            StFetchH: state_d = StExec;
            StExec: begin
                if (opc == HALT_OPC) begin
                    state_d = StHalt;
                end else begin
                    state_d = StFetchL;
                    count_d = count_q + 1'b1;
                end
            end
            StHalt:   state_d = StHalt;
            default:  state_d = StInit;
        endcase
    end

    always_comb begin
        RF_OutASel  = 3'b000;
        RF_OutBSel  = 3'b000;
        RF_FunSel   = 3'b000;
        RF_RegSel   = 4'b0000;
        RF_ScrSel   = 4'b0000;
        ALU_FunSel  = 5'b10000;
        ALU_WF      = 1'b0;
        ARF_OutCSel = 2'b00;
        ARF_OutDSel = 2'b00;
        ARF_FunSel  = 3'b000;
        ARF_RegSel  = 3'b000;
        IR_LH       = 1'b0;
        IR_Write    = 1'b0;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        MuxASel     = 2'b00;
        MuxBSel     = 2'b00;
        MuxCSel     = 1'b0;
        Halted      = 1'b0;
        // Gate on Reset so an aborted instruction never drives a write.
        if (!Reset) begin
            case (state_q)
                StInit: begin
                    ARF_RegSel = 3'b100;
                    ARF_FunSel = FunClr;
                end
                StFetchL, StFetchH: begin
                    ARF_OutDSel = 2'b00;
                    Mem_CS      = 1'b0;
                    IR_Write    = 1'b1;
                    IR_LH       = (state_q == StFetchH);
                    ARF_RegSel  = 3'b100;
                    ARF_FunSel  = FunInc;
                end
                StExec: begin
                    if (opc == HALT_OPC) begin
                        Halted = 1'b0;
                    end else if (branch_taken) begin
                        MuxBSel    = 2'b11;
                        ARF_FunSel = FunLoadLow;
                        ARF_RegSel = (opc == OpLdar) ? 3'b010 : 3'b100;
                    end else if (opc == OpLd) begin
                        ARF_OutDSel = 2'b10;
                        Mem_CS      = 1'b0;
                        MuxASel     = 2'b10;
                        RF_FunSel   = FunLoadLow;
                        RF_RegSel   = 4'b1000 >> rx;
                    end else if (opc == OpSt) begin
                        RF_OutASel  = {1'b0, rx};
                        ALU_FunSel  = 5'b10000;
                        MuxCSel     = 1'b0;
                        ARF_OutDSel = 2'b10;
                        Mem_CS      = 1'b0;
                        Mem_WR      = 1'b1;
                    end else if (is_alu_op) begin
                        RF_OutASel = {1'b0, rx};
                        RF_OutBSel = {1'b0, ry};
                        ALU_FunSel = {2'b10, opc[2:0]};
                        ALU_WF     = 1'b1;
                        MuxASel    = 2'b00;
                        RF_FunSel  = FunLoad;
                        RF_RegSel  = 4'b1000 >> rx;
                    end
                end
                StHalt:  Halted = 1'b1;
                default: Halted = 1'b0;
            endcase
        end
    end

    assign InstrCount = count_q;

endmodule
